// File: rtl/adder_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared, non-stalling pipelined adder.
// It carries each requester id down a tag pipe and routes the result back to that requester.
module adder_issue_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int LAT   = 3,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [2:0]            inflight
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_id;
  logic           win_vld;
  logic           grant;
  logic           retire;
  logic [IDW-1:0] retire_id;
  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];

  // Walk from the farthest candidate back to ptr so the nearest request wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign grant     = win_vld & en & ~rst;
  assign req_ready = grant ? (NREQ'(1) << win_id) : '0;
  assign add_a     = grant ? req_a[int'(win_id)*WIDTH +: WIDTH] : '0;
  assign add_b     = grant ? req_b[int'(win_id)*WIDTH +: WIDTH] : '0;
  assign add_cin   = grant ? req_cin[win_id] : 1'b0;
  assign ptr_nxt   = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;

  assign retire    = tag_v[LAT-1];
  assign retire_id = tag_id[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      tag_v <= '0;
    end else begin
      if (grant) ptr <= ptr_nxt;
      tag_v <= {tag_v[LAT-2:0], grant};
    end
  end

  // Ids need no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    tag_id[0] <= win_id;
    for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else if (retire) begin
      rsp_valid <= NREQ'(1) << retire_id;
      rsp_id    <= retire_id;
      rsp_sum   <= add_sum;
      rsp_cout  <= add_cout;
    end else begin
      rsp_valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 3'd0;
    end else begin
      unique case ({grant, retire})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_issue_arbiter.sv
// Directed bench for adder_issue_arbiter with a 3-edge adder model behind it.
module tb_adder_issue_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int I = 2;

  logic           clk = 1'b0;
  logic           rst, en;
  logic [N-1:0]   req_valid, req_cin, req_ready, rsp_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   add_a, add_b, add_sum, rsp_sum;
  logic           add_cin, add_cout, rsp_cout;
  logic [I-1:0]   rsp_id;
  logic [2:0]     inflight;

  logic [W:0] p1 = '0, p2 = '0, p3 = '0;
  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] a_tab [N] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [W-1:0] b_tab [N] = '{32'h00000000, 32'h30000000, 32'h60000000, 32'hC0000000};
  logic [W-1:0] s_tab [N] = '{32'h11111111, 32'h52222222, 32'h93333333, 32'h04444444};
  logic         c_tab [N] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [N-1:0] one = 4'b0001;

  always #5 clk = ~clk;

  // input reg -> pipeline reg -> output reg; never reset
  always @(posedge clk) begin
    p1 <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    p2 <= p1;
    p3 <= p2;
  end
  assign add_sum  = p3[W-1:0];
  assign add_cout = p3[W];

  adder_issue_arbiter #(.WIDTH(W), .NREQ(N), .LAT(3), .IDW(I)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .inflight(inflight)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_cin[id]      = cin;
  endtask

  // Single isolated op: grant in cycle T, response checked at T+4.
  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec, input string tag);
    set_op(id, a, b, cin);
    req_valid = one << id;
    #1;
    chk({tag, "_ready"}, req_ready, one << id);
    chk({tag, "_add_a"}, add_a, a);
    chk({tag, "_add_b"}, add_b, b);
    step();
    req_valid = '0;
    chk({tag, "_infl1"}, inflight, 1);
    step();
    step();
    chk({tag, "_early"}, rsp_valid, 0);
    chk({tag, "_infl3"}, inflight, 1);
    step();
    chk({tag, "_valid"}, rsp_valid, one << id);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_sum"}, rsp_sum, es);
    chk({tag, "_cout"}, rsp_cout, ec);
    chk({tag, "_infl0"}, inflight, 0);
  endtask

  initial begin
    int g, r;
    rst = 1'b1; en = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0; req_cin = '0;
    step();
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_inflight", inflight, 0);
    rst = 1'b0;
    req_valid = '0;

    run_op(0, 32'h0081001a, 32'h0410405e, 1'b0, 32'h04914078, 1'b0, "op0");
    run_op(2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, "ovf");
    run_op(2, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b1, "ovf_cin");

    // all four requesters back-to-back from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, a_tab[i], b_tab[i], c_tab[i] & 1'b0);
    for (int k = 0; k < 11; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) chk("rr_grant", req_ready, one << (k % 4));
      step();
      g = (k < 8) ? k + 1 : 8;
      r = (k < 3) ? 0 : k - 2;
      if (r > 8) r = 8;
      chk("rr_inflight", inflight, g - r);
      if (k >= 3) begin
        chk("rr_rsp_valid", rsp_valid, one << ((k - 3) % 4));
        chk("rr_rsp_id", rsp_id, (k - 3) % 4);
        chk("rr_rsp_sum", rsp_sum, s_tab[(k - 3) % 4]);
        chk("rr_rsp_cout", rsp_cout, c_tab[(k - 3) % 4]);
      end else begin
        chk("rr_rsp_idle", rsp_valid, 0);
      end
    end

    // ptr=2 with requesters 1 and 3 pending
    run_op(1, a_tab[1], b_tab[1], 1'b0, s_tab[1], 1'b0, "ptr_setup");
    req_valid = 4'b1010;
    #1;
    chk("wrap_first", req_ready, 4'b1000);
    step();
    chk("wrap_second", req_ready, 4'b0010);
    step();
    req_valid = '0;
    step();
    step();
    chk("wrap_rsp3", rsp_id, 3);
    chk("wrap_rsp3_sum", rsp_sum, s_tab[3]);
    step();
    chk("wrap_rsp1", rsp_id, 1);
    chk("wrap_rsp1_valid", rsp_valid, 4'b0010);
    req_valid = 4'hF;
    #1;
    chk("wrap_ptr_end", req_ready, 4'b0100);
    req_valid = '0;
    step();

    // reset while three ops are in flight
    set_op(0, a_tab[0], b_tab[0], 1'b0);
    req_valid = 4'b0001;
    step();
    step();
    step();
    chk("mid_inflight", inflight, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    step();
    rst = 1'b0;
    req_valid = '0;
    chk("mid_rst_inflight", inflight, 0);
    for (int k = 0; k < 6; k++) begin
      chk("mid_rst_discard", rsp_valid, 0);
      step();
    end
    run_op(0, 32'h0081001a, 32'h0410405e, 1'b0, 32'h04914078, 1'b0, "post_rst");

    // en low blocks grants while the in-flight op drains
    set_op(0, 32'h00000005, 32'h00000007, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("en_grant", req_ready, 4'b0001);
    step();
    en = 1'b0;
    #1;
    chk("en_block", req_ready, 0);
    chk("en_inflight1", inflight, 1);
    step();
    step();
    step();
    chk("en_drain", inflight, 0);
    chk("en_rsp_valid", rsp_valid, 4'b0001);
    chk("en_rsp_sum", rsp_sum, 32'h0000000C);
    chk("en_still_block", req_ready, 0);
    en = 1'b1;
    #1;
    chk("en_regrant", req_ready, 4'b0001);
    req_valid = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
